// File: rtl/counter_stream_checker.sv
// counter_stream_checker
//   Receive-side self-test monitor for a free-running counter bus. On every
//   qualified cycle (en=1) it checks that cnt_in is the previous sample + 1
//   (mod 2^WIDTH). It locks after LOCK_CNT consecutive good increments. Once
//   locked, a bad increment pulses err_pulse, bumps a saturating error count
//   and drops back to re-acquisition.
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   en          : sample qualifier
//   cnt_in      : counter value under test
//   load        : with en, cnt_in is a legal reload (never an error)
//   clr_err     : synchronous clear of err_count (wins over a new error)
//   locked      : FSM is in LOCKED
//   err_pulse   : one-cycle pulse per sequence error while locked
//   err_count   : saturating error count
//   expected    : value required at the next qualified sample
module counter_stream_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERRW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             load,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERRW-1:0]  err_count,
    output logic [WIDTH-1:0] expected
);
    localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {UNSYNC, ACQUIRE, LOCKED} state_t;

    state_t           state, state_n;
    logic [MW-1:0]    match, match_n;
    logic [WIDTH-1:0] expected_n;
    logic             good;
    logic             err_det;

    // The reference value itself is never needed on its own: only ref+1 is
    // ever compared or output, so that is what gets stored.
    assign good   = (cnt_in == expected);
    assign locked = (state == LOCKED);

    always_comb begin
        state_n    = state;
        match_n    = match;
        expected_n = expected;
        err_det    = 1'b0;
        if (en) begin
            // Every qualified sample becomes the new reference.
            expected_n = cnt_in + WIDTH'(1);
            case (state)
                UNSYNC: begin
                    state_n = ACQUIRE;
                    match_n = '0;
                end
                ACQUIRE: begin
                    if (good && !load) begin
                        if (match == MW'(LOCK_CNT - 1)) begin
                            state_n = LOCKED;
                            match_n = '0;
                        end else begin
                            match_n = match + MW'(1);
                        end
                    end else begin
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    if (!good && !load) begin
                        err_det = 1'b1;
                        match_n = '0;
                        state_n = ACQUIRE;
                    end
                end
                default: begin
                    state_n = UNSYNC;
                    match_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= UNSYNC;
            match     <= '0;
            expected  <= WIDTH'(1);
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            match     <= match_n;
            expected  <= expected_n;
            err_pulse <= err_det;
            // Clear beats a coincident error; the count sticks at all-ones.
            if (clr_err)
                err_count <= '0;
            else if (err_det && (err_count != '1))
                err_count <= err_count + ERRW'(1);
        end
    end
endmodule
